// File: rtl/round_timeout_ctrl.sv
// round_timeout_ctrl: per-round countdown supervisor with hit/timeout pulses.
// Optional PAUSE input enabled by defining ROUND_TIMEOUT_PAUSE_EN.
module round_timeout_ctrl #(
  parameter int SIZE = 4,
  parameter int DIV = 50,
  parameter int DEFAULT_LIMIT = 9
) (
  input  logic            CLKT,
  input  logic            R,
  input  logic            START,
  input  logic            HIT,
`ifdef ROUND_TIMEOUT_PAUSE_EN
  input  logic            PAUSE,
`endif
  input  logic [SIZE-1:0] LIMIT,
  output logic [SIZE-1:0] TEMPO,
  output logic            TICK,
  output logic            TIMEOUT,
  output logic            HIT_OK,
  output logic            BUSY
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED, ACK} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic frozen;
  logic wrap;
`ifdef ROUND_TIMEOUT_PAUSE_EN
  assign frozen = PAUSE;
`else
  assign frozen = 1'b0;
`endif
  assign wrap = presc == PW'(DIV - 1);
  always_ff @(posedge CLKT or negedge R)
    if (!R) begin
      state <= IDLE;
      TEMPO <= '0;
      presc <= '0;
      TICK <= 1'b0;
      TIMEOUT <= 1'b0;
      HIT_OK <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      TICK <= 1'b0;
      TIMEOUT <= 1'b0;
      HIT_OK <= 1'b0;
      case (state)
        IDLE:
          if (START) begin
            TEMPO <= LIMIT == '0 ? SIZE'(DEFAULT_LIMIT) : LIMIT;
            presc <= '0;
            state <= RUN;
            BUSY <= 1'b1;
          end
        RUN:
          if (HIT) begin
            state <= ACK;
            HIT_OK <= 1'b1;
          end else if (!frozen) begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) begin
              TICK <= 1'b1;
              TEMPO <= TEMPO - 1'b1;
              if (TEMPO == SIZE'(1)) begin
                state <= EXPIRED;
                TIMEOUT <= 1'b1;
              end
            end
          end
        EXPIRED: begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
        default:
          // A held button keeps us here so it cannot satisfy the next round
          if (!HIT) begin
            state <= IDLE;
            BUSY <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_round_timeout_ctrl.sv
// tb_round_timeout_ctrl: DIV=4 and DIV=1 instances checked against an elapsed-time model.
module tb_round_timeout_ctrl;
  typedef struct {
    int ph;
    int lim;
    int t;
    int tempo;
    int tick;
    int to;
    int hok;
    int busy;
  } mdl_t;
  localparam mdl_t M0 = '{default: 0};
  int dv [2] = '{4, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic pause = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] tempo [2];
  logic tick [2];
  logic timeout [2];
  logic hit_ok [2];
  logic busy [2];
  mdl_t mdl [2];
  int pass = 0;
  int total = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  round_timeout_ctrl #(.SIZE(4), .DIV(4), .DEFAULT_LIMIT(9)) u4 (
    .CLKT(clk), .R(rst_n), .START(start), .HIT(hit),
`ifdef ROUND_TIMEOUT_PAUSE_EN
    .PAUSE(pause),
`endif
    .LIMIT(limit), .TEMPO(tempo[0]), .TICK(tick[0]), .TIMEOUT(timeout[0]),
    .HIT_OK(hit_ok[0]), .BUSY(busy[0]));
  round_timeout_ctrl #(.SIZE(4), .DIV(1), .DEFAULT_LIMIT(9)) u1 (
    .CLKT(clk), .R(rst_n), .START(start), .HIT(hit),
`ifdef ROUND_TIMEOUT_PAUSE_EN
    .PAUSE(pause),
`endif
    .LIMIT(limit), .TEMPO(tempo[1]), .TICK(tick[1]), .TIMEOUT(timeout[1]),
    .HIT_OK(hit_ok[1]), .BUSY(busy[1]));
  function void chk(string n, int a, int e);
    total++;
    if (a != e) $display("FAIL %s actual=%0d required=%0d", n, a, e);
    else pass++;
  endfunction
  // Remaining time is the loaded limit minus whole time units of unpaused RUN cycles
  function automatic mdl_t step(mdl_t m, int d);
    m.tick = 0;
    m.to = 0;
    m.hok = 0;
    case (m.ph)
      0: if (start) begin
        m.lim = limit == 0 ? 9 : int'(limit);
        m.t = 0;
        m.tempo = m.lim;
        m.ph = 1;
      end
      1: if (hit) begin
        m.ph = 3;
        m.hok = 1;
      end else if (!pause) begin
        m.t++;
        if (m.t % d == 0) begin
          m.tick = 1;
          m.tempo = m.lim - m.t / d;
          if (m.tempo == 0) begin
            m.ph = 2;
            m.to = 1;
          end
        end
      end
      2: m.ph = 0;
      default: if (!hit) m.ph = 0;
    endcase
    m.busy = m.ph != 0 ? 1 : 0;
    return m;
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++) mdl[i] <= !rst_n ? M0 : step(mdl[i], dv[i]);
  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_tempo", i), int'(tempo[i]), mdl[i].tempo);
        chk($sformatf("u%0d_tick", i), int'(tick[i]), mdl[i].tick);
        chk($sformatf("u%0d_timeout", i), int'(timeout[i]), mdl[i].to);
        chk($sformatf("u%0d_hit_ok", i), int'(hit_ok[i]), mdl[i].hok);
        chk($sformatf("u%0d_busy", i), int'(busy[i]), mdl[i].busy);
        chk($sformatf("u%0d_exclusive", i), int'(timeout[i] & hit_ok[i]), 0);
      end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int nt, first, toc, acc, bacc;
    nxt();
    chk("rst_tempo", int'(tempo[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) nxt();
    start = 1'b1; limit = 4'd3; nxt(); start = 1'b0;
    chk("t1_busy", int'(busy[0]), 1);
    chk("t1_load", int'(tempo[0]), 3);
    nt = 0; first = 0; toc = 0;
    for (int c = 2; c <= 14; c++) begin
      nxt();
      if (tick[0]) begin
        nt++;
        if (first == 0) first = c;
      end
      if (timeout[0]) toc = c;
    end
    chk("t1_ticks", nt, 3);
    chk("t1_first_tick", first, 5);
    chk("t1_timeout_cycle", toc, 13);
    chk("t1_tempo_end", int'(tempo[0]), 0);
    chk("t1_busy_end", int'(busy[0]), 0);
    repeat (2) nxt();
    start = 1'b1; limit = 4'd5; nxt(); start = 1'b0;
    repeat (8) nxt();
    chk("t2_tempo_before_hit", int'(tempo[0]), 3);
    hit = 1'b1; nxt();
    chk("t2_hit_ok", int'(hit_ok[0]), 1);
    chk("t2_tempo_hold", int'(tempo[0]), 3);
    acc = 0; bacc = 0;
    repeat (5) begin
      nxt();
      acc += int'(hit_ok[0]) + int'(timeout[0]);
      bacc += int'(busy[0]);
    end
    chk("t2_no_repeat_pulse", acc, 0);
    chk("t2_ack_held", bacc, 5);
    hit = 1'b0; nxt();
    chk("t2_idle_after_release", int'(busy[0]), 0);
    repeat (2) nxt();
    start = 1'b1; limit = 4'd2; nxt(); start = 1'b0;
    repeat (7) nxt();
    chk("t3_tempo_last", int'(tempo[0]), 1);
    hit = 1'b1; nxt();
    chk("t3_hit_ok", int'(hit_ok[0]), 1);
    chk("t3_no_timeout", int'(timeout[0]), 0);
    chk("t3_tempo_kept", int'(tempo[0]), 1);
    hit = 1'b0; repeat (3) nxt();
    start = 1'b1; limit = 4'd0; nxt(); start = 1'b0;
    chk("t4_default_limit", int'(tempo[0]), 9);
    nxt();
    start = 1'b1; limit = 4'd5; nxt(); start = 1'b0;
    toc = 0;
    for (int c = 4; c <= 60 && toc == 0; c++) begin
      nxt();
      if (timeout[0]) toc = c;
    end
    chk("t4_restart_ignored", toc, 37);
    repeat (3) nxt();
    start = 1'b1; limit = 4'd3; nxt(); start = 1'b0;
    repeat (5) nxt();
    chk("t5_tempo_before_reset", int'(tempo[0]), 2);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tempo", int'(tempo[0]), 0);
    chk("t5_async_busy", int'(busy[0]), 0);
    chk("t5_async_pulses", int'(tick[0]) + int'(timeout[0]) + int'(hit_ok[0]), 0);
    nxt();
    rst_n = 1'b1; hit = 1'b1;
    acc = 0;
    repeat (4) begin
      nxt();
      acc += int'(busy[0]) + int'(hit_ok[0]) + int'(busy[1]) + int'(hit_ok[1]);
    end
    chk("t5_hit_alone", acc, 0);
    hit = 1'b0; repeat (2) nxt();
    start = 1'b1; limit = 4'd2; nxt(); start = 1'b0;
    chk("t6_no_tick_c1", int'(tick[1]), 0);
    nxt();
    chk("t6_tick_c2", int'(tick[1]), 1);
    chk("t6_tempo_c2", int'(tempo[1]), 1);
    nxt();
    chk("t6_tick_c3", int'(tick[1]), 1);
    chk("t6_timeout_c3", int'(timeout[1]), 1);
    repeat (12) nxt();
`ifdef ROUND_TIMEOUT_PAUSE_EN
    start = 1'b1; limit = 4'd2; nxt(); start = 1'b0;
    pause = 1'b1; repeat (5) nxt(); pause = 1'b0;
    chk("t6_pause_frozen", int'(tempo[1]), 2);
    toc = 0;
    for (int c = 7; c <= 20 && toc == 0; c++) begin
      nxt();
      if (timeout[1]) toc = c;
    end
    chk("t6_pause_delay", toc, 8);
    repeat (12) nxt();
`endif
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst_n = ($urandom % 400) != 0;
      start = ($urandom % 6) == 0;
      limit = 4'($urandom);
      if ($urandom % 8 == 0) hit = ~hit;
`ifdef ROUND_TIMEOUT_PAUSE_EN
      pause = ($urandom % 4) == 0;
`endif
    end
    rst_n = 1'b1;
    repeat (2) nxt();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/round_timeout_ctrl.md
Name: round_timeout_ctrl

Overview:
- Per-round countdown supervisor for the Genius game datapath. It sits on the opposite side of the tick/enable interface from the elapsed-time up-counter.
- Generates the time-base tick from the system clock, counts down the player's allowed response time, and reports one of two outcomes with a single-cycle pulse: player hit in time, or timeout.
- Consumed by the game FSM to advance or fail a round.

Parameters:
- SIZE, 4: width of the time counter and the LIMIT input.
- DIV, 50: CLKT cycles per time unit (prescaler modulus, >= 1).
- DEFAULT_LIMIT, 9: load value used when LIMIT == 0 at START.

Ports:
- CLKT  in   1     system clock, rising edge.
- R     in   1     reset, asynchronous, active-low (R == 0 resets).
- START in   1     arm a round; sampled only in IDLE.
- HIT   in   1     debounced player input, level.
- LIMIT in   SIZE  allowed time units; sampled on accepted START.
- TEMPO out  SIZE  remaining time units (registered).
- TICK  out  1     one-cycle pulse per elapsed time unit while RUN.
- TIMEOUT out 1    one-cycle pulse: time exhausted.
- HIT_OK out 1     one-cycle pulse: hit accepted within time.
- BUSY  out  1     high in RUN, EXPIRED, ACK.

Behaviour:
- Reset (R = 0, asynchronous):
  - State IDLE; TEMPO = 0; prescaler = 0.
  - TICK, TIMEOUT, HIT_OK, BUSY = 0.
  - Reset asserted in any state aborts the round immediately. No outcome pulse is produced.
- Prescaler:
  - Width is $clog2(DIV), minimum 1 bit.
  - Runs only in RUN. Counts 0..DIV-1, then wraps to 0.
  - A wrap is a tick event. TICK is high in the cycle after the prescaler reaches DIV-1.
  - DIV = 1: a tick event occurs every RUN cycle.
- IDLE:
  - On START = 1: TEMPO <= (LIMIT == 0) ? DEFAULT_LIMIT : LIMIT; prescaler <= 0; go to RUN.
  - BUSY = 1 from the next cycle.
  - HIT is ignored in IDLE.
- RUN:
  - Tick event with TEMPO > 1: TEMPO decrements by 1.
  - Tick event with TEMPO == 1: TEMPO <= 0; go to EXPIRED.
  - Time from START to the TIMEOUT pulse is exactly TEMPO_loaded*DIV + 1 cycles.
  - HIT = 1: go to ACK; TEMPO holds its current value.
  - HIT and a tick event in the same cycle: HIT wins. No decrement, no timeout.
  - START in RUN is ignored. There is no restart mid-round.
- EXPIRED:
  - Lasts one cycle; TIMEOUT = 1 during it.
  - Then go to IDLE; BUSY drops.
- ACK:
  - HIT_OK = 1 in the first ACK cycle only.
  - Stay in ACK until HIT == 0, then go to IDLE. A held button must not start or satisfy another round.
- Outputs are registered and derived from state/counters. No combinational path from inputs to outputs.
- TIMEOUT and HIT_OK are never high in the same cycle.
- TEMPO never underflows. It holds its value in IDLE until the next accepted START.

Optional Feature:
- Macro: ROUND_TIMEOUT_PAUSE_EN.
- With the macro defined:
  - Adds input port PAUSE (1 bit).
  - While PAUSE = 1 in RUN: the prescaler and TEMPO freeze and no TICK is issued. HIT is still accepted.
  - PAUSE has no effect in other states.
  - Releasing PAUSE resumes counting from the frozen prescaler value.
- Without the macro: no PAUSE port; RUN always counts.

Test Plan:
- DIV=4, LIMIT=3, START pulse, HIT low -> TICK on 3 cycles spaced 4 apart; TEMPO 3->2->1->0; TIMEOUT pulses once at cycle 13 after START; BUSY=0 after.
- DIV=4, LIMIT=5, HIT raised after 2 ticks -> HIT_OK pulses one cycle; TEMPO holds 3; no TIMEOUT; HIT held 6 cycles keeps ACK; IDLE after HIT falls.
- HIT asserted in the exact cycle of the final tick (TEMPO=1) -> HIT_OK=1, TIMEOUT stays 0, TEMPO remains 1.
- LIMIT=0 with START -> TEMPO loads 9 (DEFAULT_LIMIT); START re-pulsed during RUN -> ignored, countdown continues unchanged.
- R driven low mid-RUN (TEMPO=2) -> TEMPO=0, BUSY=0, no pulses, immediately without a clock edge; after release, HIT alone does nothing.
- DIV=1, LIMIT=2 -> TICK in 2 consecutive cycles, TIMEOUT 3 cycles after START; with ROUND_TIMEOUT_PAUSE_EN and PAUSE=1 for 5 cycles mid-round -> timeout delayed by exactly 5 cycles.
